// File: rtl/shr_chain_ctrl_if.sv
// rtl/shr_chain_ctrl_if.sv - request/status and chain-pin bundle for shr_chain_ctrl
// SHR_CTRL_READBACK_EN adds the SHR_DOUT tail input and the readback image.
interface shr_chain_ctrl_if #(
  parameter int CHAIN_LEN = 1024
);
  logic                 start;
  logic                 clear;
  logic                 fill_ones;
  logic [CHAIN_LEN-1:0] data;
  logic                 busy;
  logic                 done;
  logic                 SHR_CLK;
  logic                 SHR_DATA;
  logic                 SHR_LATCH;
`ifdef SHR_CTRL_READBACK_EN
  logic                 SHR_DOUT;
  logic [CHAIN_LEN-1:0] readback;

  modport master (
    output start, clear, fill_ones, data, SHR_DOUT,
    input  busy, done, SHR_CLK, SHR_DATA, SHR_LATCH, readback
  );
  modport slave (
    input  start, clear, fill_ones, data, SHR_DOUT,
    output busy, done, SHR_CLK, SHR_DATA, SHR_LATCH, readback
  );
`else
  modport master (
    output start, clear, fill_ones, data,
    input  busy, done, SHR_CLK, SHR_DATA, SHR_LATCH
  );
  modport slave (
    input  start, clear, fill_ones, data,
    output busy, done, SHR_CLK, SHR_DATA, SHR_LATCH
  );
`endif
endinterface

// File: rtl/shr_chain_ctrl.sv
// rtl/shr_chain_ctrl.sv - serially loads an image MSB-first into an external shift-register chain
// Optional chain readback is enabled by defining SHR_CTRL_READBACK_EN.
module shr_chain_ctrl #(
  parameter int CHAIN_LEN = 1024,
  parameter int CLK_DIV   = 25
) (
  input logic             CLOCK_50,
  input logic             RESET,
  shr_chain_ctrl_if.slave bus
);
  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int CNT_W = $clog2(CHAIN_LEN);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LATCH, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [CNT_W-1:0]     bitcnt_q, bitcnt_d;
  logic [CHAIN_LEN-1:0] shreg_q, shreg_d;
  logic                 busy_q, done_q, shr_clk_q, shr_data_q, shr_latch_q;
  logic                 div_last;

  assign div_last = (div_q == DIV_W'(CLK_DIV - 1));

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    case (state_q)
      S_IDLE: begin
        if (bus.clear || bus.fill_ones || bus.start) begin
          if (bus.clear)          shreg_d = '0;
          else if (bus.fill_ones) shreg_d = '1;
          else                    shreg_d = bus.data;
          bitcnt_d = CNT_W'(CHAIN_LEN - 1);
          div_d    = '0;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        if (div_last) begin
          div_d   = '0;
          state_d = S_HIGH;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_HIGH: begin
        if (div_last) begin
          div_d = '0;
          if (bitcnt_q == '0) begin
            state_d = S_LATCH;
          end else begin
            shreg_d  = {shreg_q[CHAIN_LEN-2:0], 1'b0};
            bitcnt_d = bitcnt_q - CNT_W'(1);
            state_d  = S_SETUP;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_LATCH: begin
        if (div_last) begin
          div_d   = '0;
          state_d = S_DONE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every pin is a flop aligned with the state register.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      shr_clk_q   <= 1'b0;
      shr_data_q  <= 1'b0;
      shr_latch_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      shr_clk_q   <= (state_d == S_HIGH);
      shr_latch_q <= (state_d == S_LATCH);
      shr_data_q  <= ((state_d == S_SETUP) || (state_d == S_HIGH)) ? shreg_d[CHAIN_LEN-1] : 1'b0;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.SHR_CLK   = shr_clk_q;
  assign bus.SHR_DATA  = shr_data_q;
  assign bus.SHR_LATCH = shr_latch_q;

`ifdef SHR_CTRL_READBACK_EN
  logic [CHAIN_LEN-1:0] readback_q;

  // The chain tail is captured as SHR_CLK rises, before the chain itself has shifted.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      readback_q <= '0;
    end else if ((state_q == S_SETUP) && (state_d == S_HIGH)) begin
      readback_q <= {readback_q[CHAIN_LEN-2:0], bus.SHR_DOUT};
    end
  end

  assign bus.readback = readback_q;
`endif
endmodule

// File: tb/tb_shr_chain_ctrl.sv
// tb/tb_shr_chain_ctrl.sv - directed and randomized checks of shr_chain_ctrl against a chain-level model
module tb_shr_chain_ctrl;
  localparam int N       = 8;
  localparam int D       = 2;
  localparam int BUSY_N  = (2 * N + 1) * D + 1;
  localparam int LATCH_E = 2 * N * D;
  localparam int DONE_E  = (2 * N + 1) * D;

  logic CLOCK_50 = 1'b0;
  logic RESET    = 1'b1;
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   done_total = 0;
  logic cap_q[$];

  shr_chain_ctrl_if #(.CHAIN_LEN(N)) bus ();

  shr_chain_ctrl #(.CHAIN_LEN(N), .CLK_DIV(D)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge bus.SHR_CLK) cap_q.push_back(bus.SHR_DATA);

  always @(negedge CLOCK_50) if (bus.done === 1'b1) done_total++;

`ifdef SHR_CTRL_READBACK_EN
  logic [N-1:0] chain_m;
  logic         preload = 1'b0;
  logic         clk_prev;

  always @(posedge CLOCK_50) begin
    clk_prev <= bus.SHR_CLK;
    if (preload) chain_m <= 8'h5A;
    else if (bus.SHR_CLK === 1'b1 && clk_prev === 1'b0) chain_m <= {chain_m[N-2:0], bus.SHR_DATA};
  end
  assign bus.SHR_DOUT = chain_m[N-1];
`endif

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_run(input logic [N-1:0] img, input logic c, input logic f, input logic s,
                        input logic [N-1:0] exp, input logic [N-1:0] post_data,
                        input bit hold, input int pulse_at, input string tag);
    int busy_n, latch_first, latch_n, done_e, done_n, e;
    bit ended, latch_data_ok;
    logic [N-1:0] got;
    bus.data = img; bus.clear = c; bus.fill_ones = f; bus.start = s;
    cap_q.delete();
    tick();
    if (!hold) begin bus.clear = 1'b0; bus.fill_ones = 1'b0; bus.start = 1'b0; end
    bus.data = post_data;
    check({tag, " busy@0"}, {31'd0, bus.busy}, 32'd1);
    check({tag, " first bit"}, {31'd0, bus.SHR_DATA}, {31'd0, exp[N-1]});
    busy_n = 0; latch_first = -1; latch_n = 0; done_e = -1; done_n = 0; ended = 0;
    latch_data_ok = 1;
    for (e = 0; e < 4 * BUSY_N; e++) begin
      if (bus.busy !== 1'b1) begin ended = 1; break; end
      busy_n++;
      if (bus.SHR_LATCH === 1'b1) begin
        if (latch_first < 0) latch_first = e;
        latch_n++;
        if (bus.SHR_DATA !== 1'b0) latch_data_ok = 0;
      end
      if (bus.done === 1'b1) begin done_e = e; done_n++; end
      if (e == pulse_at) bus.start = 1'b1;
      else if (!hold) bus.start = 1'b0;
      tick();
    end
    check({tag, " ended"}, {31'd0, ended}, 32'd1);
    check({tag, " busy cycles"}, busy_n, BUSY_N);
    check({tag, " latch edge"}, latch_first, LATCH_E);
    check({tag, " latch cycles"}, latch_n, D);
    check({tag, " latch data low"}, {31'd0, latch_data_ok}, 32'd1);
    check({tag, " done edge"}, done_e, DONE_E);
    check({tag, " done count"}, done_n, 1);
    check({tag, " rises"}, cap_q.size(), N);
    got = '0;
    foreach (cap_q[i]) got = {got[N-2:0], cap_q[i]};
    check({tag, " chain image"}, {24'd0, got}, {24'd0, exp});
  endtask

  initial begin
    logic [N-1:0] img, exp;
    logic c, f, s;
    int d0;
    bus.start = 1'b0; bus.clear = 1'b0; bus.fill_ones = 1'b0; bus.data = '0;

    tick(); tick();
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset clk", {31'd0, bus.SHR_CLK}, 32'd0);
    check("reset data", {31'd0, bus.SHR_DATA}, 32'd0);
    check("reset latch", {31'd0, bus.SHR_LATCH}, 32'd0);
    RESET = 1'b0;
    tick();

    do_run(8'hA5, 0, 0, 1, 8'hA5, 8'hA5, 0, -1, "basic");
    do_run(8'hA5, 0, 0, 1, 8'hA5, 8'h3C, 0, -1, "data change");

    d0 = done_total;
    do_run(8'hC3, 1, 1, 1, 8'h00, 8'hC3, 0, -1, "all three");
    repeat (6) begin
      check("all three single run", {31'd0, bus.busy}, 32'd0);
      tick();
    end
    check("all three done total", done_total - d0, 1);
    do_run(8'h12, 0, 1, 1, 8'hFF, 8'h12, 0, -1, "fill+start");

    do_run(8'h5C, 0, 0, 1, 8'h5C, 8'h5C, 1, -1, "held run1");
    do_run(8'h5C, 0, 0, 1, 8'h5C, 8'h5C, 1, -1, "held run2");
    bus.start = 1'b0;
    tick();

    do_run(8'h96, 0, 0, 1, 8'h96, 8'h96, 0, 10, "mid pulse");
    repeat (4) begin
      check("mid pulse no rerun", {31'd0, bus.busy}, 32'd0);
      tick();
    end

    repeat (5) begin
      img = N'($urandom);
      c = 1'($urandom); f = 1'($urandom); s = 1'($urandom);
      if (!(c || f || s)) s = 1'b1;
      exp = c ? 8'h00 : (f ? 8'hFF : img);
      do_run(img, c, f, s, exp, N'($urandom), 0, -1, "random");
      repeat ($urandom_range(0, 3)) tick();
    end

    d0 = done_total;
    bus.data = 8'hA5; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    RESET = 1'b1;
    tick();
    check("rst clk", {31'd0, bus.SHR_CLK}, 32'd0);
    check("rst data", {31'd0, bus.SHR_DATA}, 32'd0);
    check("rst latch", {31'd0, bus.SHR_LATCH}, 32'd0);
    check("rst busy", {31'd0, bus.busy}, 32'd0);
    RESET = 1'b0;
    check("rst no done", done_total - d0, 0);
    do_run(8'hA5, 0, 0, 1, 8'hA5, 8'hA5, 0, -1, "after reset");

`ifdef SHR_CTRL_READBACK_EN
    preload = 1'b1;
    tick();
    preload = 1'b0;
    tick();
    do_run(8'hA5, 0, 0, 1, 8'hA5, 8'hA5, 0, -1, "readback run");
    check("readback value", {24'd0, bus.readback}, 32'h5A);
    check("model chain", {24'd0, chain_m}, 32'hA5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
